spm_seq_ctrl: RTL

//  Sequencer for the spm serial-parallel multiplier array (the genblk csa/hsum cells).
//  - Accepts one operand pair per valid/ready handshake.
//  - Holds multiplicand x parallel on the array; streams multiplier y LSB-first.
//  - Deserialises the serial product bit p into a 2N-bit result.
//  - Returns the result through a valid/ready output handshake.

---
 rtl/spm_seq_ctrl_pkg.sv | 15 +
 rtl/spm_seq_ctrl_if.sv | 27 ++
 rtl/spm_seq_ctrl_shreg.sv | 47 ++++
 rtl/spm_seq_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/spm_seq_ctrl_pkg.sv
// Shared types and helpers for the spm serial-parallel multiplier sequencer.
package spm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width: must hold 0 .. 2N+P_LAT without wrapping.
  function automatic int cnt_w(input int n, input int p_lat);
    return $clog2(2 * n + p_lat + 1);
  endfunction

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Operand/result handshakes plus the parallel/serial lines to the spm array.
// The master side is the environment (operand producer, result consumer and
// the array's serial product output); the slave side is the sequencer.
interface spm_seq_ctrl_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_x;
  logic [N-1:0]   in_y;
  logic [N-1:0]   spm_x;
  logic           spm_y;
  logic           spm_p;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_p;

  modport master (
    output in_valid, in_x, in_y, out_ready, spm_p,
    input  in_ready, out_valid, out_p, spm_x, spm_y
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready, spm_p,
    output in_ready, out_valid, out_p, spm_x, spm_y
  );
endinterface

// File: rtl/spm_seq_ctrl_shreg.sv
// Right-shifting register with parallel load. The vacated MSB either repeats
// the current MSB (sign extension) or takes the serial input.
module spm_seq_shreg #(
  parameter int WIDTH    = 8,
  parameter bit FILL_MSB = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shift_val;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shift_val[gi] = q_q[gi+1];
    end
  endgenerate
  assign shift_val[WIDTH-1] = FILL_MSB ? q_q[WIDTH-1] : ser_i;

  // Next value: load wins over shift, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = shift_val;
    end
  end

  // State register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the spm serial-parallel multiplier array: holds x parallel on
// the array, streams y LSB-first (extended to 2N bits), collects the serial
// product and hands the 2N-bit result out through a valid/ready handshake.
module spm_seq_ctrl
  import spm_seq_pkg::*;
#(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b1,
  parameter int P_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst,
  spm_seq_ctrl_if.slave bus,
  output logic          busy
);
  localparam int             CW     = cnt_w(N, P_LAT);
  localparam logic [CW-1:0]  LAST_C = CW'(2 * N + P_LAT - 1);
  localparam logic [CW-1:0]  FEED_C = CW'(2 * N);
  localparam logic [CW-1:0]  PLAT_C = CW'(P_LAT);
  localparam logic [1:0]     S_IDLE = 2'(IDLE);
  localparam logic [1:0]     S_RUN  = 2'(RUN);
  localparam logic [1:0]     S_DONE = 2'(DONE);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   spm_x_q, spm_x_d;
  logic [2*N-1:0] out_p_q, out_p_d;
  logic [N-1:0]   ysh;
  logic [2*N-1:0] psh;
  logic           accept;
  logic           running;
  logic           capture;
  logic           unused_bits;

  assign accept  = bus.in_valid & bus.in_ready;
  assign running = (state_q == S_RUN);
  assign capture = running && (cnt_q >= PLAT_C);

  // y serialiser: after N shifts the fill supplies the sign (or zero) bits.
  spm_seq_shreg #(.WIDTH(N), .FILL_MSB(SIGNED)) u_ysh (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (bus.in_y),
    .shift_i    (running),
    .ser_i      (1'b0),
    .q_o        (ysh)
  );

  // p deserialiser: product bits enter at the MSB and walk down to bit 0.
  spm_seq_shreg #(.WIDTH(2 * N), .FILL_MSB(1'b0)) u_psh (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i ('0),
    .shift_i    (capture),
    .ser_i      (bus.spm_p),
    .q_o        (psh)
  );

  // Only the serial end of ysh and the upper bits of psh are consumed here.
  assign unused_bits = ^{ysh[N-1:1], psh[0]};

  // Next-state: accept in IDLE, count through RUN, release result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spm_x_d = spm_x_q;
    out_p_d = out_p_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          spm_x_d = bus.in_x;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          // Fold the final capture in directly rather than waiting a cycle.
          out_p_d = {bus.spm_p, psh[2*N-1:1]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          spm_x_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      spm_x_q <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spm_x_q <= spm_x_d;
      out_p_q <= out_p_d;
    end
  end

  // Beyond 2N feed cycles the array is drained with zeros.
  assign bus.spm_y     = running && (cnt_q < FEED_C) ? ysh[0] : 1'b0;
  assign bus.spm_x     = spm_x_q;
  assign bus.in_ready  = (state_q == S_IDLE) & rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_p     = out_p_q;
  assign busy          = (state_q != S_IDLE);
endmodule
